// File: rtl/iir_pkg.sv
// Shared types and the sample-format conversion for the IIR sample pacer.
package iir_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        COOL = 1'b1
    } pacer_state_t;

    // Widest word the conversion helper handles (input and output).
    localparam int unsigned QFMT_MAXW = 64;

    // Signed Q1.(win-1) -> Q(ndint).(ndfrac): sign-extend, then left-align the fraction.
    function automatic logic [QFMT_MAXW-1:0] to_qfmt(
        input logic [QFMT_MAXW-1:0] x,
        input int unsigned          win,
        input int unsigned          ndint,
        input int unsigned          ndfrac
    );
        logic [QFMT_MAXW-1:0] lo_mask;
        logic [QFMT_MAXW-1:0] sx;
        logic                 sign;
        lo_mask = ~({QFMT_MAXW{1'b1}} << win);
        sign    = x[6'(win - 1)];
        sx      = (x & lo_mask) | ({QFMT_MAXW{sign}} & ~lo_mask);
        return (sx << (ndfrac - (win - 1))) & ~({QFMT_MAXW{1'b1}} << (ndint + ndfrac));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular synchronous FIFO; level is the single source of truth for full/empty.
module sync_fifo #(
    parameter int unsigned Width = 16,
    parameter int unsigned Depth = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [Width-1:0]        wr_data,
    output logic [Width-1:0]        rd_data_c,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(Depth):0]  level,
    output logic [$clog2(Depth):0]  level_nxt_c
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned LW = $clog2(Depth) + 1;

    logic [Width-1:0] mem [Depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign full      = (level == LW'(Depth));
    assign empty     = (level == '0);
    assign rd_data_c = mem[rd_ptr];

    // Occupancy after this edge; push and pop together cancel out.
    always_comb begin
        level_nxt_c = level + LW'(push) - LW'(pop);
    end

    // Pointer and level registers; pointers wrap naturally at Depth.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level_nxt_c;
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (push && rst_n) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/iir_sample_pacer.sv
// Sample pacer feeding the second-order IIR section: buffers samples, converts
// them to the section's data format and spaces dv_out strobes >= Nspacing apart.
// Optional statistics outputs are enabled by defining IIR_PACER_STATS_EN.
module iir_sample_pacer
    import iir_pkg::*;
#(
    parameter int unsigned Win      = 16,
    parameter int unsigned Ndint    = 3,
    parameter int unsigned Ndfrac   = 22,
    parameter int unsigned Depth    = 16,
    parameter int unsigned Nspacing = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [Win-1:0]            s_data,
    output logic                      dv_out,
    output logic [Ndint+Ndfrac-1:0]   d_out,
    output logic [$clog2(Depth):0]    level,
    output logic                      busy
`ifdef IIR_PACER_STATS_EN
    ,
    output logic [31:0]               stat_issued,
    output logic [$clog2(Depth):0]    stat_maxlevel
`endif
);

    localparam int unsigned OW = Ndint + Ndfrac;
    localparam int unsigned LW = $clog2(Depth) + 1;
    localparam int unsigned CW = $clog2(Nspacing);

    pacer_state_t   state;
    pacer_state_t   state_nxt;
    logic [CW-1:0]  cool;
    logic [CW-1:0]  cool_nxt;
    logic           issue_c;
    logic [OW-1:0]  d_nxt;
    logic           busy_nxt;

    logic           push_c;
    logic           fifo_full;
    logic           fifo_empty;
    logic [Win-1:0] fifo_rd_data;
    logic [LW-1:0]  fifo_level_nxt;

    assign push_c = s_valid && s_ready && !fifo_full;

    sync_fifo #(
        .Width (Win),
        .Depth (Depth)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push_c),
        .pop         (issue_c),
        .wr_data     (s_data),
        .rd_data_c   (fifo_rd_data),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .level       (level),
        .level_nxt_c (fifo_level_nxt)
    );

    // Issue when idle, or when the cooldown has fully expired with data waiting.
    always_comb begin
        state_nxt = state;
        cool_nxt  = cool;
        issue_c   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) issue_c = 1'b1;
            end
            COOL: begin
                if (cool != '0)       cool_nxt  = cool - CW'(1);
                else if (!fifo_empty) issue_c   = 1'b1;
                else                  state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (issue_c) begin
            state_nxt = COOL;
            cool_nxt  = CW'(Nspacing - 1);
        end
        d_nxt    = issue_c ? OW'(to_qfmt(QFMT_MAXW'(fifo_rd_data), Win, Ndint, Ndfrac)) : d_out;
        busy_nxt = (fifo_level_nxt != '0) || (state_nxt == COOL);
    end

    // State, cooldown and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cool    <= '0;
            dv_out  <= 1'b0;
            d_out   <= '0;
            busy    <= 1'b0;
            s_ready <= 1'b0;
        end else begin
            state   <= state_nxt;
            cool    <= cool_nxt;
            dv_out  <= issue_c;
            d_out   <= d_nxt;
            busy    <= busy_nxt;
            s_ready <= (fifo_level_nxt != LW'(Depth));
        end
    end

`ifdef IIR_PACER_STATS_EN
    // Strobe counter and FIFO high-water mark.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_issued   <= '0;
            stat_maxlevel <= '0;
        end else begin
            if (issue_c) stat_issued <= stat_issued + 32'd1;
            if (fifo_level_nxt > stat_maxlevel) stat_maxlevel <= fifo_level_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_iir_sample_pacer.sv
// Self-checking bench for iir_sample_pacer against a queue-based reference model.
module tb_iir_sample_pacer;

    localparam int unsigned WIN   = 16;
    localparam int unsigned NINT  = 3;
    localparam int unsigned NFRAC = 22;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned NSP   = 6;
    localparam int unsigned OW    = NINT + NFRAC;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;
    localparam int unsigned SH    = NFRAC - WIN + 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           s_valid;
    logic           s_ready;
    logic [WIN-1:0] s_data;
    logic           dv_out;
    logic [OW-1:0]  d_out;
    logic [LW-1:0]  level;
    logic           busy;
`ifdef IIR_PACER_STATS_EN
    logic [31:0]    stat_issued;
    logic [LW-1:0]  stat_maxlevel;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    iir_sample_pacer #(
        .Win      (WIN),
        .Ndint    (NINT),
        .Ndfrac   (NFRAC),
        .Depth    (DEPTH),
        .Nspacing (NSP)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .dv_out  (dv_out),
        .d_out   (d_out),
        .level   (level),
        .busy    (busy)
`ifdef IIR_PACER_STATS_EN
        ,
        .stat_issued   (stat_issued),
        .stat_maxlevel (stat_maxlevel)
`endif
    );

    // Reference conversion: value times 2^(NFRAC-(WIN-1)), kept to OW bits.
    function automatic logic [OW-1:0] model_conv(input logic [WIN-1:0] s);
        longint v;
        v = longint'($signed(s)) * (longint'(1) << SH);
        return OW'(v);
    endfunction

    // Reference model: a strobe is allowed whenever data waits and at least
    // NSP edges have passed since the previous strobe.
    logic [WIN-1:0] mq[$];
    bit             m_ready = 1'b0;
    bit             m_dv    = 1'b0;
    bit             m_busy  = 1'b0;
    logic [OW-1:0]  m_d     = '0;
    int             m_edge  = 0;
    int             m_last  = -1000;
    int unsigned    m_issued = 0;
    int             m_max   = 0;

    always @(posedge clk) begin
        bit do_push;
        if (!rst_n) begin
            mq.delete();
            m_ready  = 1'b0;
            m_dv     = 1'b0;
            m_busy   = 1'b0;
            m_d      = '0;
            m_last   = -1000;
            m_issued = 0;
            m_max    = 0;
        end else begin
            do_push = s_valid && m_ready;
            m_dv = 1'b0;
            if (mq.size() > 0 && (m_edge - m_last) >= int'(NSP)) begin
                m_d = model_conv(mq.pop_front());
                m_dv = 1'b1;
                m_last = m_edge;
                m_issued++;
            end
            if (do_push) mq.push_back(s_data);
            m_ready = (mq.size() != int'(DEPTH));
            m_busy  = (mq.size() != 0) || ((m_edge - m_last) < int'(NSP));
            if (mq.size() > m_max) m_max = mq.size();
        end
        m_edge++;
    end

    task automatic test_reset();
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_s_ready cyc=%0d got=%b exp=0", i, s_ready); end
            total++;
            if (dv_out !== 1'b0) begin bad++; $display("FAIL reset_dv cyc=%0d got=%b exp=0", i, dv_out); end
            total++;
            if (level !== '0 || busy !== 1'b0 || d_out !== '0) begin
                bad++; $display("FAIL reset_state cyc=%0d level=%0d busy=%b d_out=%h exp 0/0/0", i, level, busy, d_out);
            end
        end
        rst_n   = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        total++;
        if (s_ready !== 1'b1) begin bad++; $display("FAIL release_s_ready got=%b exp=1", s_ready); end
        total++;
        if (level !== '0) begin bad++; $display("FAIL release_level got=%0d exp=0", level); end
    endtask

    task automatic test_single_sample();
        int pulse_at = -1;
        int busy_cnt = 0;
        s_valid = 1'b1;
        s_data  = 16'h4000;
        @(negedge clk);
        s_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            total++;
            if (dv_out !== m_dv || busy !== m_busy) begin
                bad++; $display("FAIL single_cycle k=%0d dv=%b busy=%b exp dv=%b busy=%b", k, dv_out, busy, m_dv, m_busy);
            end
            if (dv_out === 1'b1 && pulse_at < 0) begin
                pulse_at = k;
                total++;
                if (d_out !== 25'h0200000) begin bad++; $display("FAIL single_d_out got=%h exp=0200000", d_out); end
            end
            if (pulse_at >= 0 && busy === 1'b1) busy_cnt++;
            @(negedge clk);
        end
        total++;
        if (pulse_at != 1) begin bad++; $display("FAIL single_latency pulse_cycle=%0d exp=1", pulse_at); end
        total++;
        if (busy_cnt != int'(NSP)) begin bad++; $display("FAIL single_busy_len got=%0d exp=%0d", busy_cnt, NSP); end
    endtask

    task automatic test_burst();
        int pulses[$];
        logic [OW-1:0] dvals[$];
        int dut_peak = 0;
        int mod_peak = 0;
        for (int c = 0; c < 80; c++) begin
            total++;
            if (dv_out !== m_dv || level !== LW'(mq.size())) begin
                bad++; $display("FAIL burst_cycle c=%0d dv=%b level=%0d exp dv=%b level=%0d", c, dv_out, level, m_dv, mq.size());
            end
            if (dv_out === 1'b1) begin pulses.push_back(c); dvals.push_back(d_out); end
            if (int'(level) > dut_peak) dut_peak = int'(level);
            if (mq.size() > mod_peak) mod_peak = mq.size();
            s_valid = (c < 10);
            s_data  = WIN'(c + 1);
            @(negedge clk);
        end
        s_valid = 1'b0;
        total++;
        if (pulses.size() != 10) begin
            bad++; $display("FAIL burst_count got=%0d exp=10", pulses.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                total++;
                if (dvals[i] !== OW'((i + 1) << SH)) begin
                    bad++; $display("FAIL burst_d idx=%0d got=%h exp=%h", i, dvals[i], OW'((i + 1) << SH));
                end
                if (i > 0) begin
                    total++;
                    if (pulses[i] - pulses[i-1] != int'(NSP)) begin
                        bad++; $display("FAIL burst_spacing idx=%0d got=%0d exp=%0d", i, pulses[i] - pulses[i-1], NSP);
                    end
                end
            end
        end
        total++;
        if (dut_peak != mod_peak || dut_peak != 8) begin
            bad++; $display("FAIL burst_peak got=%0d exp=8 model=%0d", dut_peak, mod_peak);
        end
    endtask

    task automatic test_fill();
        logic [WIN-1:0] data[20];
        logic [OW-1:0]  got[$];
        int  sent = 0;
        bit  prev_acc = 1'b0;
        int  cyc = 0;
        bit  saw_full = 1'b0;
        for (int i = 0; i < 20; i++) data[i] = WIN'($urandom);
        while (got.size() < 20 && cyc < 400) begin
            total++;
            if (s_ready !== m_ready || level !== LW'(mq.size()) || dv_out !== m_dv) begin
                bad++; $display("FAIL fill_cycle c=%0d rdy=%b lvl=%0d dv=%b exp rdy=%b lvl=%0d dv=%b",
                                cyc, s_ready, level, dv_out, m_ready, mq.size(), m_dv);
            end
            if (level === LW'(DEPTH)) begin
                saw_full = 1'b1;
                total++;
                if (s_ready !== 1'b0) begin bad++; $display("FAIL fill_ready_at_full got=%b exp=0", s_ready); end
            end
            if (dv_out === 1'b1) got.push_back(d_out);
            if (prev_acc) sent++;
            s_valid  = (sent < 20);
            s_data   = (sent < 20) ? data[sent] : '0;
            prev_acc = s_valid && s_ready;
            @(negedge clk);
            cyc++;
        end
        s_valid = 1'b0;
        total++;
        if (got.size() != 20 || !saw_full) begin
            bad++; $display("FAIL fill_done got=%0d exp=20 saw_full=%b exp=1", got.size(), saw_full);
        end
        for (int i = 0; i < got.size(); i++) begin
            total++;
            if (got[i] !== model_conv(data[i])) begin
                bad++; $display("FAIL fill_order idx=%0d got=%h exp=%h", i, got[i], model_conv(data[i]));
            end
        end
        repeat (NSP + 2) @(negedge clk);
    endtask

    task automatic test_extremes();
        logic [WIN-1:0] vals[4];
        vals[0] = 16'h8000; vals[1] = 16'h7FFF; vals[2] = 16'h0001; vals[3] = 16'hFFFF;
        for (int v = 0; v < 4; v++) begin
            s_valid = 1'b1;
            s_data  = vals[v];
            @(negedge clk);
            s_valid = 1'b0;
            for (int k = 0; k < 8; k++) begin
                total++;
                if (dv_out !== m_dv || d_out !== m_d) begin
                    bad++; $display("FAIL extreme_cycle val=%h k=%0d dv=%b d=%h exp dv=%b d=%h", vals[v], k, dv_out, d_out, m_dv, m_d);
                end
                if (dv_out === 1'b1) begin
                    total++;
                    if (d_out !== model_conv(vals[v])) begin
                        bad++; $display("FAIL extreme_value val=%h got=%h exp=%h", vals[v], d_out, model_conv(vals[v]));
                    end
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        bit found = 1'b0;
        logic [OW-1:0] first_d = '0;
        for (int c = 0; c < 200 && !hit; c++) begin
            if (mq.size() == 5 && (m_edge - 1 - m_last) >= 1 && (m_edge - 1 - m_last) < int'(NSP)) begin
                hit = 1'b1;
            end else begin
                s_valid = (c < 12);
                s_data  = WIN'(16'h0100 + c);
                @(negedge clk);
            end
        end
        total++;
        if (!hit) begin bad++; $display("FAIL midreset_setup reached=%b exp=1", hit); end
        rst_n   = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        total++;
        if (level !== '0 || dv_out !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin
            bad++; $display("FAIL midreset_state level=%0d dv=%b busy=%b rdy=%b exp 0/0/0/0", level, dv_out, busy, s_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (s_ready !== 1'b1 || level !== '0) begin
            bad++; $display("FAIL midreset_release rdy=%b level=%0d exp 1/0", s_ready, level);
        end
        s_valid = 1'b1;
        s_data  = 16'h0001;
        @(negedge clk);
        s_valid = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (dv_out === 1'b1) begin found = 1'b1; first_d = d_out; end
            else @(negedge clk);
        end
        total++;
        if (!found || first_d !== OW'(1 << SH)) begin
            bad++; $display("FAIL midreset_first found=%b got=%h exp=%h", found, first_d, OW'(1 << SH));
        end
        repeat (NSP + 2) @(negedge clk);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            total++;
            if (s_ready !== m_ready || dv_out !== m_dv || d_out !== m_d ||
                level !== LW'(mq.size()) || busy !== m_busy) begin
                bad++; $display("FAIL random_cycle c=%0d rdy=%b dv=%b d=%h lvl=%0d busy=%b exp %b %b %h %0d %b",
                                c, s_ready, dv_out, d_out, level, busy, m_ready, m_dv, m_d, mq.size(), m_busy);
            end
            s_valid = ($urandom_range(0, 99) < 45);
            s_data  = WIN'($urandom);
            @(negedge clk);
        end
        s_valid = 1'b0;
`ifdef IIR_PACER_STATS_EN
        total++;
        if (stat_issued !== 32'(m_issued) || stat_maxlevel !== LW'(m_max)) begin
            bad++; $display("FAIL stats issued=%0d max=%0d exp %0d %0d", stat_issued, stat_maxlevel, m_issued, m_max);
        end
`endif
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        test_reset();
        test_single_sample();
        test_burst();
        test_fill();
        test_extremes();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
